// File: rtl/aes_pkg.sv
// Shared AES substitution tables, FSM state type and lane-count legality check.
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] SBOX_FWD [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] SBOX_INV [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    // Lane count must be a power of two up to 16 that divides the block evenly.
    function automatic bit lanes_legal(input int nbytes, input int lanes);
        bit pow2_ok;
        pow2_ok = (lanes == 1) || (lanes == 2) || (lanes == 4) || (lanes == 8) || (lanes == 16);
        return pow2_ok && (lanes <= nbytes) && ((nbytes % lanes) == 0);
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Single-byte AES substitution, forward or inverse table selected by inv.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] in,
    input  logic       inv,
    output logic [7:0] out
);

    // Pure table lookup; synthesis maps each table to logic.
    always_comb begin
        out = inv ? SBOX_INV[in] : SBOX_FWD[in];
    end

endmodule

// File: rtl/sub_bytes_engine.sv
// Multi-lane AES SubBytes engine: LANES bytes of the held state are
// substituted per beat, NBYTES/LANES beats per block, valid/ready on both sides.
//
// state | meaning
// IDLE  | no block held, ready to accept
// RUN   | substituting one group of LANES bytes per cycle
// DONE  | result presented on out_state until downstream takes it
module sub_bytes_engine
    import aes_pkg::*;
#(
    parameter int NBYTES = 16,
    parameter int LANES  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [8*NBYTES-1:0]   in_state,
    input  logic                  in_inv,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [8*NBYTES-1:0]   out_state,
    output logic                  out_inv,
    output logic                  busy
);

    localparam int BEATS  = NBYTES / LANES;
    localparam int BW     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int BSLOTS = 1 << BW;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    if (!lanes_legal(NBYTES, LANES)) begin : g_bad_lanes
        $error("sub_bytes_engine: LANES=%0d illegal for NBYTES=%0d", LANES, NBYTES);
    end

    state_t              fsm;
    state_t              fsm_nxt;
    logic [BW-1:0]       beat;
    logic [8*NBYTES-1:0] state_reg;
    logic [8*NBYTES-1:0] state_run;
    logic                mode_reg;
    logic                accept;
    logic                last_beat;
    logic [7:0]          lane_cand [LANES][BSLOTS];
    logic [7:0]          lane_in   [LANES];
    logic [7:0]          lane_out  [LANES];

    assign in_ready  = (fsm == IDLE) || ((fsm == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign last_beat = (beat == LAST_BEAT);
    assign out_valid = (fsm == DONE);
    assign busy      = (fsm != IDLE);
    assign out_state = state_reg;
    assign out_inv   = mode_reg;

    // Each lane sees byte beat*LANES+lane of the held state.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        for (genvar b = 0; b < BSLOTS; b++) begin : g_slot
            if (b < BEATS) begin : g_used
                assign lane_cand[l][b] = state_reg[8*(b*LANES+l) +: 8];
            end else begin : g_unused
                assign lane_cand[l][b] = 8'h00;
            end
        end
        assign lane_in[l] = lane_cand[l][beat];

        aes_sbox u_sbox (
            .in  (lane_in[l]),
            .inv (mode_reg),
            .out (lane_out[l])
        );
    end

    // Only the bytes belonging to the current beat take the substituted value.
    for (genvar i = 0; i < NBYTES; i++) begin : g_byte
        localparam int BI = i / LANES;
        assign state_run[8*i +: 8] = (beat == BW'(BI)) ? lane_out[i % LANES] : state_reg[8*i +: 8];
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm <= IDLE;
        end else begin
            fsm <= fsm_nxt;
        end
    end

    // Next-state logic; a DONE handoff with a waiting block goes straight to RUN.
    always_comb begin
        fsm_nxt = fsm;
        case (fsm)
            IDLE: if (accept) fsm_nxt = RUN;
            RUN:  if (last_beat) fsm_nxt = DONE;
            DONE: begin
                if (accept) begin
                    fsm_nxt = RUN;
                end else if (out_ready) begin
                    fsm_nxt = IDLE;
                end
            end
            default: fsm_nxt = IDLE;
        endcase
    end

    // Block capture on accept, in-place substitution while running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat      <= '0;
            state_reg <= '0;
            mode_reg  <= 1'b0;
        end else if (accept) begin
            beat      <= '0;
            state_reg <= in_state;
            mode_reg  <= in_inv;
        end else if (fsm == RUN) begin
            state_reg <= state_run;
            beat      <= last_beat ? '0 : beat + BW'(1);
        end
    end

endmodule

// File: doc/sub_bytes_engine.md
Name: sub_bytes_engine

Overview:
Multi-lane AES byte-substitution engine for a full AES state. It applies the forward S-box (encrypt) or inverse S-box (decrypt) to all NBYTES bytes of the state. Each cycle it processes LANES bytes, so one block takes NBYTES/LANES cycles; the area/throughput trade-off is set by LANES. It sits between AddRoundKey and ShiftRows in the round datapath and uses valid/ready handshakes on both sides.

Parameters:
NBYTES, 16, bytes per state block; byte i occupies bits [8*i+7:8*i].
LANES, 4, S-box instances and bytes substituted per cycle; legal values 1, 2, 4, 8, 16; NBYTES % LANES == 0 is checked at elaboration.
BEATS, NBYTES/LANES, derived local constant, not overridable.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream block available
in_ready  output  1  engine can accept a block this cycle
in_state  input  8*NBYTES  state block to substitute
in_inv  input  1  0 = forward S-box, 1 = inverse S-box; sampled on accept
out_valid  output  1  substituted block available
out_ready  input  1  downstream accepts the block
out_state  output  8*NBYTES  substituted block
out_inv  output  1  mode the block was processed with
busy  output  1  high in RUN or DONE

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low. Reset forces the FSM to IDLE, the beat counter to 0, the state register to 0, out_valid=0, out_inv=0 and busy=0. in_ready goes high on the first clock after rst_n deasserts.
- FSM states are IDLE, RUN and DONE.
- in_ready = (fsm==IDLE) || (fsm==DONE && out_ready).
- Accept occurs when in_valid && in_ready. On accept:
  - state_reg <= in_state, mode_reg <= in_inv, beat <= 0.
  - The FSM moves to RUN.
- RUN, each cycle: bytes [beat*LANES .. beat*LANES+LANES-1] of state_reg are replaced by S(byte) or S^-1(byte), selected by mode_reg. The other bytes hold.
  - If beat == BEATS-1: the FSM moves to DONE and beat resets to 0.
  - Otherwise: beat increments.
- Latency: the accept edge is cycle 0. out_valid rises BEATS cycles later. With LANES=NBYTES this is 1 cycle.
- DONE:
  - out_valid=1; out_state=state_reg and out_inv=mode_reg, both stable until the handshake.
  - On out_valid && out_ready without a simultaneous accept, the FSM returns to IDLE.
  - If out_ready and in_valid arrive in the same cycle, the output handshake and the new accept complete together and the FSM goes directly to RUN with no bubble. Sustained throughput is therefore one block per BEATS+1 cycles.
- Backpressure: DONE holds indefinitely while out_ready=0. in_ready stays 0 during that time.
- Input changes: in_state and in_inv are ignored when not accepting. A mode change mid-block has no effect on the block in flight.
- out_state is a register output with no combinational path from inputs. in_ready depends combinationally on out_ready only in DONE.
- Reset mid-block (rst_n asserted in RUN or DONE) discards the block; no partial output is produced.
- beat counter width is max(1, $clog2(BEATS)).

Decomposition:
- Package aes_pkg holds:
  - The 256-entry forward S-box constant (standard AES table; 0x00->0x63, 0xff->0x16).
  - The 256-entry inverse S-box constant.
  - The FSM state enum.
  - A function that checks LANES legality.
- Sub-module aes_sbox (combinational; ports in[7:0], inv, out[7:0]) is instantiated LANES times. Each instance is fed through a byte mux indexed by beat.

Test Plan:
1. Forward, LANES=4: in_state bytes 0..15 = 19 3d e3 be a0 f4 e2 2b 9a c6 8d 2a e9 f8 48 08, in_inv=0, out_ready=1 -> out_valid exactly 4 cycles after accept; out bytes = d4 27 11 ae e0 bf 98 f1 b8 b4 5d e5 1e 41 52 30; out_inv=0.
2. Inverse round-trip: feed the result of test 1 with in_inv=1 -> original bytes 19 3d ... 08 returned. Also check single bytes: 0x63->0x00, 0xed->0x53, 0x16->0xff.
3. Backpressure: out_ready=0 for 10 cycles after out_valid -> out_state stable, in_ready=0, second in_valid block not taken. Raise out_ready with in_valid high -> same-cycle handoff, next out_valid exactly BEATS cycles later.
4. Exhaustive sweep, LANES=1, 16 and 2 builds: all 256 byte values placed in every lane position, both modes -> matches the package tables. Latency is 16, 1 and 8 cycles respectively.
5. Reset in RUN at beat 2: rst_n low for one cycle -> out_valid=0, busy=0, in_ready=1 after release. The next block completes correctly, with no stale bytes from the aborted block.
6. Mode toggle: in_inv toggled every cycle while RUN -> output uses the mode sampled at accept; out_inv matches it.
